// File: rtl/cmp_result_filter_pkg.sv
// cmp_filt_pkg: result codes, FSM states and flag-decoding helpers for cmp_result_filter
// Contents: res_t (2-bit result code), RES_NONE/LT/EQ/GT, state_t (S_IDLE/S_ARM/S_LOCK),
//           one_hot3() legality test and flag_code() flag-to-code mapping.
package cmp_filt_pkg;
    typedef logic [1:0] res_t;
    localparam res_t RES_NONE = 2'd0;
    localparam res_t RES_LT   = 2'd1;
    localparam res_t RES_EQ   = 2'd2;
    localparam res_t RES_GT   = 2'd3;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_LOCK = 2'd2} state_t;
    function automatic logic one_hot3(logic gt, logic eq, logic lt);
        return (gt ^ eq ^ lt) & ~(gt & eq & lt);
    endfunction
    function automatic res_t flag_code(logic gt, logic eq, logic lt);
        return gt ? RES_GT : eq ? RES_EQ : lt ? RES_LT : RES_NONE;
    endfunction
endpackage

// File: rtl/cmp_result_filter_if.sv
// cmp_result_filter_if: comparator-flag input bundle and filtered-result output bundle
// master: drives clr, in_valid, gt, eq, lt; observes stable_res, locked, chg_pulse, err, *_cnt.
// slave:  the filter side of the same signals.
interface cmp_result_filter_if #(parameter int CNT_W = 8);
    logic               clr;
    logic               in_valid;
    logic               gt;
    logic               eq;
    logic               lt;
    cmp_filt_pkg::res_t stable_res;
    logic               locked;
    logic               chg_pulse;
    logic               err;
    logic [CNT_W-1:0]   gt_cnt;
    logic [CNT_W-1:0]   eq_cnt;
    logic [CNT_W-1:0]   lt_cnt;
    modport master (
        output clr, in_valid, gt, eq, lt,
        input  stable_res, locked, chg_pulse, err, gt_cnt, eq_cnt, lt_cnt
    );
    modport slave (
        input  clr, in_valid, gt, eq, lt,
        output stable_res, locked, chg_pulse, err, gt_cnt, eq_cnt, lt_cnt
    );
endinterface

// File: rtl/cmp_result_filter_sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (count enable), cnt (count value).
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + W'(1);
endmodule

// File: rtl/cmp_result_filter.sv
// cmp_result_filter: debounces one-hot gt/eq/lt comparator flags into a locked result
// Ports: clk, rst (sync, active-high), bus (cmp_result_filter_if.slave): clr, in_valid, gt, eq, lt in;
//        stable_res, locked, chg_pulse, err, gt_cnt, eq_cnt, lt_cnt out (all registered).
// Build option: define CMP_FILT_STICKY_ERR_EN to make err sticky until clr/rst; otherwise err pulses.
module cmp_result_filter
    import cmp_filt_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 8
) (
    input logic                 clk,
    input logic                 rst,
    cmp_result_filter_if.slave  bus
);
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    res_t       cand, stable_q, s;
    logic [3:0] run_len, run_nx;
    state_t     state, state_nx;
    logic       legal, illegal, lock, chg_q, err_q, err_nx;
    always_comb begin
        legal    = bus.in_valid && !bus.clr && one_hot3(bus.gt, bus.eq, bus.lt);
        illegal  = bus.in_valid && !bus.clr && !one_hot3(bus.gt, bus.eq, bus.lt);
        s        = flag_code(bus.gt, bus.eq, bus.lt);
        // cand is NONE after reset or an illegal sample, so a legal s never matches it there
        run_nx   = illegal ? 4'd0 : !legal ? run_len : s != cand ? 4'd1 :
                   run_len == STABLE ? run_len : run_len + 4'd1;
        lock     = legal && run_nx == STABLE && s != stable_q;
        state_nx = lock ? S_LOCK :
                   state == S_IDLE && legal ? S_ARM :
                   state == S_ARM && illegal && stable_q == RES_NONE ? S_IDLE : state;
`ifdef CMP_FILT_STICKY_ERR_EN
        err_nx   = err_q | illegal;
`else
        err_nx   = illegal;
`endif
    end
    always_ff @(posedge clk)
        if (rst || bus.clr) begin
            cand     <= RES_NONE;
            run_len  <= '0;
            state    <= S_IDLE;
            stable_q <= RES_NONE;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cand     <= illegal ? RES_NONE : legal ? s : cand;
            run_len  <= run_nx;
            state    <= state_nx;
            stable_q <= lock ? s : stable_q;
            chg_q    <= lock;
            err_q    <= err_nx;
        end
    assign bus.stable_res = stable_q;
    assign bus.locked     = state == S_LOCK;
    assign bus.chg_pulse  = chg_q;
    assign bus.err        = err_q;
    sat_counter #(.W(CNT_W)) u_gt (.clk(clk), .rst(rst), .clr(bus.clr), .inc(legal && s == RES_GT), .cnt(bus.gt_cnt));
    sat_counter #(.W(CNT_W)) u_eq (.clk(clk), .rst(rst), .clr(bus.clr), .inc(legal && s == RES_EQ), .cnt(bus.eq_cnt));
    sat_counter #(.W(CNT_W)) u_lt (.clk(clk), .rst(rst), .clr(bus.clr), .inc(legal && s == RES_LT), .cnt(bus.lt_cnt));
endmodule
